// File: rtl/aes_pkg.sv
// Shared AES encodings: round types, round counts, key-length codes and
// the encipher controller FSM states.
package aes_pkg;

    typedef enum logic [1:0] {
        INIT_ROUND  = 2'd0,
        MAIN_ROUND  = 2'd1,
        FINAL_ROUND = 2'd2
    } round_type_e;

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    typedef enum logic [1:0] {
        CTRL_IDLE  = 2'd0,
        CTRL_INIT  = 2'd1,
        CTRL_MAIN  = 2'd2,
        CTRL_FINAL = 2'd3
    } ctrl_state_e;

    // Without 256-bit support the keylen request is ignored.
    function automatic logic [3:0] num_rounds(input logic keylen, input bit support_256);
        return (keylen == AES_256_BIT_KEY && support_256) ? AES_256_NUM_ROUNDS
                                                          : AES_128_NUM_ROUNDS;
    endfunction

endpackage

// File: rtl/aes_encipher_ctrl_if.sv
// Request/response handshake between the core FSM (master) and the encipher
// controller (slave).
interface aes_encipher_ctrl_if;

    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic         ready;
    logic [127:0] result;
    logic         result_valid;

    modport master (
        output next, keylen, block,
        input  ready, result, result_valid
    );

    modport slave (
        input  next, keylen, block,
        output ready, result, result_valid
    );

endinterface

// File: rtl/aes_encipher_ctrl.sv
// Sequencer for the external combinational encipher round: owns the state
// register and round counter, iterating one round per cycle.
module aes_encipher_ctrl
    import aes_pkg::*;
#(
    parameter bit SUPPORT_256 = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_encipher_ctrl_if.slave  core,
    input  logic [127:0]        round_key,
    input  logic [127:0]        round_result,
    output logic [3:0]          round,
    output logic [1:0]          round_type,
    output logic [127:0]        rnd_block
);

    ctrl_state_e  fsm_q;
    logic [3:0]   round_ctr_q;
    logic [3:0]   nr_q;
    logic [127:0] state_q;
    logic [127:0] result_q;
    logic         result_valid_q;
    logic         ready_q;
    round_type_e  rtype;

    // The round key goes straight to the external datapath; it is only
    // present here so the key memory and datapath wire up symmetrically.
    logic unused_round_key;
    assign unused_round_key = ^round_key;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q          <= CTRL_IDLE;
            round_ctr_q    <= 4'd0;
            nr_q           <= AES_128_NUM_ROUNDS;
            state_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            ready_q        <= 1'b1;
        end else begin
            unique case (fsm_q)
                CTRL_IDLE: begin
                    if (core.next) begin
                        state_q        <= core.block;
                        nr_q           <= num_rounds(core.keylen, SUPPORT_256);
                        ready_q        <= 1'b0;
                        result_valid_q <= 1'b0;
                        round_ctr_q    <= 4'd0;
                        fsm_q          <= CTRL_INIT;
                    end
                end
                CTRL_INIT: begin
                    state_q     <= round_result;
                    round_ctr_q <= 4'd1;
                    fsm_q       <= CTRL_MAIN;
                end
                CTRL_MAIN: begin
                    state_q     <= round_result;
                    round_ctr_q <= round_ctr_q + 4'd1;
                    if (round_ctr_q == nr_q - 4'd1) begin
                        fsm_q <= CTRL_FINAL;
                    end
                end
                CTRL_FINAL: begin
                    result_q       <= round_result;
                    state_q        <= round_result;
                    result_valid_q <= 1'b1;
                    ready_q        <= 1'b1;
                    fsm_q          <= CTRL_IDLE;
                end
                default: begin
                    fsm_q          <= CTRL_IDLE;
                    round_ctr_q    <= 4'd0;
                    nr_q           <= AES_128_NUM_ROUNDS;
                    state_q        <= '0;
                    result_q       <= '0;
                    result_valid_q <= 1'b0;
                    ready_q        <= 1'b1;
                end
            endcase
        end
    end

    // Datapath controls depend only on registered state, never on inputs.
    always_comb begin
        round = 4'd0;
        rtype = INIT_ROUND;
        unique case (fsm_q)
            CTRL_MAIN: begin
                round = round_ctr_q;
                rtype = MAIN_ROUND;
            end
            CTRL_FINAL: begin
                round = nr_q;
                rtype = FINAL_ROUND;
            end
            default: begin
                round = 4'd0;
                rtype = INIT_ROUND;
            end
        endcase
    end

    assign round_type        = rtype;
    assign rnd_block         = state_q;
    assign core.ready        = ready_q;
    assign core.result       = result_q;
    assign core.result_valid = result_valid_q;

endmodule
